// File: rtl/plab3_mem_sec_line_responder.sv
// plab3_mem_sec_line_responder
// Line-granularity memory responder for the blocking cache's memory port.
// Each 128-bit line carries a one-bit security tag. A requester may touch a
// line only when its domain is at least the line's tag. One request is in
// flight at a time; a down-counter models the memory latency.

module plab3_mem_sec_line_responder #(
    parameter int p_opaque_nbits = 8,
    parameter int p_nlines       = 256,
    parameter int p_latency      = 2
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        memreq_val,
    output logic                        memreq_rdy,
    input  logic [p_opaque_nbits+166:0] memreq_msg,
    input  logic                        memreq_domain,

    output logic                        memresp_val,
    input  logic                        memresp_rdy,
    output logic [p_opaque_nbits+134:0] memresp_msg,
    output logic                        memresp_domain,

    output logic [7:0]                  viol_count
);

    // ------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------
    localparam int O       = p_opaque_nbits;
    localparam int RESP_W  = O + 135;
    localparam int IDX_W   = (p_nlines > 1) ? $clog2(p_nlines) : 1;
    localparam int CNT_W   = (p_latency > 1) ? $clog2(p_latency + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(p_latency);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] TYPE_WRITE      = 3'd1;
    localparam logic [2:0] TYPE_WRITE_INIT = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                rdy_q,       rdy_d;
    logic                val_q,       val_d;
    logic [RESP_W-1:0]   resp_msg_q,  resp_msg_d;
    logic                resp_dom_q,  resp_dom_d;
    logic [7:0]          viol_q,      viol_d;

    logic [127:0]        data_mem_q [p_nlines];
    logic                tag_mem_q  [p_nlines];

    // ------------------------------------------------------------------
    // Request field decode
    // ------------------------------------------------------------------
    logic [2:0]          req_type_s;
    logic [O-1:0]        req_opaque_s;
    logic [31:0]         req_addr_s;
    logic [3:0]          req_len_s;
    logic [127:0]        req_data_s;
    logic [IDX_W-1:0]    req_idx_s;

    assign req_data_s   = memreq_msg[127:0];
    assign req_len_s    = memreq_msg[131:128];
    assign req_addr_s   = memreq_msg[163:132];
    assign req_opaque_s = memreq_msg[164 +: O];
    assign req_type_s   = memreq_msg[164 + O +: 3];
    assign req_idx_s    = req_addr_s[4 +: IDX_W];

    // Offset bits, aliasing upper address bits and len never affect the access.
    logic unused_s;
    assign unused_s = ^{req_addr_s[3:0], req_addr_s[31:4+IDX_W], req_len_s};

    logic                accept_s;
    logic                resp_fire_s;
    logic                is_write_s;
    logic                is_init_s;
    logic                line_tag_s;
    logic                allowed_s;
    logic [127:0]        resp_data_s;
    logic                data_we_s;
    logic                tag_we_s;

    assign accept_s    = memreq_val & rdy_q;
    assign resp_fire_s = val_q & memresp_rdy;

    // Access check and response payload for the request on the bus.
    always_comb begin
        is_write_s  = (req_type_s == TYPE_WRITE);
        is_init_s   = (req_type_s == TYPE_WRITE_INIT);
        line_tag_s  = tag_mem_q[req_idx_s];
        // domain >= tag: secure reaches everything, non-secure only tag-0 lines
        allowed_s   = memreq_domain | ~line_tag_s;
        if (is_write_s || is_init_s) begin
            resp_data_s = 128'd0;
        end else if (allowed_s) begin
            resp_data_s = data_mem_q[req_idx_s];
        end else begin
            resp_data_s = 128'd0;
        end
        // WRITE_INIT is the loading path and bypasses the tag check
        data_we_s = accept_s & (is_init_s | (is_write_s & allowed_s));
        tag_we_s  = accept_s & is_init_s;
    end

    // Next-state logic for the request/response FSM, counter and outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdy_d      = rdy_q;
        val_d      = val_q;
        resp_msg_d = resp_msg_q;
        resp_dom_d = resp_dom_q;
        viol_d     = viol_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // Response is frozen here so later bus values cannot leak in.
                    resp_msg_d = {req_type_s, req_opaque_s, 4'd0, resp_data_s};
                    resp_dom_d = line_tag_s;
                    if (!is_init_s && !allowed_s && (viol_q != 8'hFF)) begin
                        viol_d = viol_q + 8'd1;
                    end else begin
                        viol_d = viol_q;
                    end
                    rdy_d = 1'b0;
                    if (p_latency == 0) begin
                        state_d = ST_RESP;
                        val_d   = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RESP;
                    cnt_d   = {CNT_W{1'b0}};
                    val_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (resp_fire_s) begin
                    state_d = ST_IDLE;
                    val_d   = 1'b0;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                val_d   = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // FSM, counter, response register and violation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rdy_q      <= 1'b1;
            val_q      <= 1'b0;
            resp_msg_q <= {RESP_W{1'b0}};
            resp_dom_q <= 1'b0;
            viol_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
            val_q      <= val_d;
            resp_msg_q <= resp_msg_d;
            resp_dom_q <= resp_dom_d;
            viol_q     <= viol_d;
        end
    end

    // Line data and security tag arrays, updated at the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_nlines; i++) begin
                data_mem_q[i] <= 128'd0;
                tag_mem_q[i]  <= 1'b0;
            end
        end else begin
            if (data_we_s) begin
                data_mem_q[req_idx_s] <= req_data_s;
            end
            if (tag_we_s) begin
                tag_mem_q[req_idx_s] <= memreq_domain;
            end
        end
    end

    assign memreq_rdy     = rdy_q;
    assign memresp_val    = val_q;
    assign memresp_msg    = resp_msg_q;
    assign memresp_domain = resp_dom_q;
    assign viol_count     = viol_q;

endmodule

// File: tb/tb_plab3_mem_sec_line_responder.sv
// Directed bench for plab3_mem_sec_line_responder with a reference model
// and a scoreboard of expected responses.

module tb_plab3_mem_sec_line_responder;

    localparam int O   = 8;
    localparam int NL  = 256;
    localparam int LAT = 2;

    logic           clk;
    logic           reset;
    logic           memreq_val;
    logic           memreq_rdy;
    logic [174:0]   memreq_msg;
    logic           memreq_domain;
    logic           memresp_val;
    logic           memresp_rdy;
    logic [142:0]   memresp_msg;
    logic           memresp_domain;
    logic [7:0]     viol_count;

    plab3_mem_sec_line_responder #(
        .p_opaque_nbits (O),
        .p_nlines       (NL),
        .p_latency      (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memreq_msg     (memreq_msg),
        .memreq_domain  (memreq_domain),
        .memresp_val    (memresp_val),
        .memresp_rdy    (memresp_rdy),
        .memresp_msg    (memresp_msg),
        .memresp_domain (memresp_domain),
        .viol_count     (viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [127:0] data_m [NL];
    logic         tag_m  [NL];
    int           viol_m;
    // Scoreboard entry: {check_domain, domain, resp_msg}
    logic [144:0] exp_q [$];

    int checks;
    int errors;

    localparam logic [127:0] D_INIT = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
    localparam logic [127:0] D_55   = 128'h55555555_55555555_55555555_55555555;
    localparam logic [127:0] D_W20  = 128'hA5A5F00D_12345678_CAFEBABE_0BADC0DE;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) begin
            data_m[i] = 128'd0;
            tag_m[i]  = 1'b0;
        end
        viol_m = 0;
    endtask

    task automatic model_push(input logic [2:0] t, input logic [7:0] op,
                              input logic [31:0] addr, input logic [127:0] data,
                              input logic dom);
        logic [7:0]   idx;
        logic         is_w;
        logic         is_i;
        logic         ltag;
        logic         ok;
        logic [127:0] rdata;
        idx   = addr[11:4];
        is_w  = (t == 3'd1);
        is_i  = (t == 3'd2);
        ltag  = tag_m[idx];
        ok    = dom | ~ltag;
        rdata = (is_w || is_i || !ok) ? 128'd0 : data_m[idx];
        if (!is_i && !ok && viol_m < 255) viol_m++;
        if (is_i) begin
            data_m[idx] = data;
            tag_m[idx]  = dom;
        end else if (is_w && ok) begin
            data_m[idx] = data;
        end
        exp_q.push_back({~is_i, ltag, t, op, 4'd0, rdata});
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] t, input logic [7:0] op,
                         input logic [31:0] addr, input logic [127:0] data,
                         input logic dom);
        logic [191:0] junk;
        model_push(t, op, addr, data, dom);
        chk("req_rdy_idle", memreq_rdy, 1);
        memreq_msg    = {t, op, addr, 4'hF, data};
        memreq_domain = dom;
        memreq_val    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        memreq_val    = 1'b0;
        junk          = {6{32'($urandom)}};
        memreq_msg    = junk[174:0];
        memreq_domain = ~dom;
        chk("req_rdy_busy", memreq_rdy, 0);
    endtask

    task automatic collect(input int stall);
        int           k;
        logic [144:0] e;
        k = 1;
        while (!memresp_val && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("resp_latency", k, LAT + 1);
        chk("resp_val", memresp_val, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {145{1'b1}};
        chk("resp_msg", memresp_msg, e[142:0]);
        if (e[144]) chk("resp_domain", memresp_domain, e[143]);
        chk("req_rdy_in_resp", memreq_rdy, 0);
        chk("viol_count", viol_count, viol_m);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_val", memresp_val, 1);
            chk("stall_msg", memresp_msg, e[142:0]);
            chk("stall_domain", memresp_domain, e[143]);
            chk("stall_req_rdy", memreq_rdy, 0);
        end
        memresp_rdy = 1'b1;
        @(negedge clk);
        memresp_rdy = 1'b0;
        chk("post_hs_val", memresp_val, 0);
        chk("post_hs_req_rdy", memreq_rdy, 1);
    endtask

    task automatic txn(input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] addr, input logic [127:0] data,
                       input logic dom, input int stall);
        issue(t, op, addr, data, dom);
        collect(stall);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        memreq_val    = 1'b0;
        memreq_msg    = 175'd0;
        memreq_domain = 1'b0;
        memresp_rdy   = 1'b0;
        model_clear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req_rdy", memreq_rdy, 1);
        chk("rst_resp_val", memresp_val, 0);
        chk("rst_resp_msg", memresp_msg, 0);
        chk("rst_resp_domain", memresp_domain, 0);
        chk("rst_viol", viol_count, 0);

        // Fresh line reads as zero, opaque echoed
        txn(3'd0, 8'h11, 32'h0000_0040, 128'd0, 1'b0, 0);
        // Load a secure line, read it back securely
        txn(3'd2, 8'h22, 32'h0000_0010, D_INIT, 1'b1, 0);
        txn(3'd0, 8'h23, 32'h0000_0010, 128'd0, 1'b1, 0);
        chk("viol_after_secure_read", viol_count, 0);
        // Non-secure read and write of the secure line are denied
        txn(3'd0, 8'h24, 32'h0000_0010, 128'd0, 1'b0, 0);
        chk("viol_after_denied_read", viol_count, 1);
        txn(3'd1, 8'h25, 32'h0000_0010, D_55, 1'b0, 0);
        txn(3'd0, 8'h26, 32'h0000_0010, 128'd0, 1'b1, 0);
        chk("viol_after_denied_write", viol_count, 2);
        // Non-secure write to a tag-0 line, then an aliased read
        txn(3'd1, 8'h30, 32'h0000_0020, D_W20, 1'b0, 0);
        txn(3'd0, 8'h31, 32'h0000_0020 + NL * 16, 128'd0, 1'b0, 0);
        txn(3'd0, 8'h32, 32'h0000_0027, 128'd0, 1'b1, 0);
        // Unknown type behaves as READ and echoes its type
        txn(3'd5, 8'h33, 32'h0000_001C, 128'd0, 1'b1, 0);
        // Back-pressure: response held for 5 cycles
        txn(3'd0, 8'h40, 32'h0000_0020, 128'd0, 1'b0, 5);

        // Saturation of the violation counter
        for (int i = 0; i < 256; i++) begin
            txn(3'd0, 8'(i), 32'h0000_0010, 128'd0, 1'b0, 0);
        end
        chk("viol_saturated", viol_count, 255);

        // Reset while a request is waiting
        issue(3'd1, 8'h50, 32'h0000_0030, D_55, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        model_clear();
        chk("midrst_req_rdy", memreq_rdy, 1);
        chk("midrst_resp_val", memresp_val, 0);
        chk("midrst_viol", viol_count, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", memresp_val, 0);
        end
        // Tags and data cleared by reset
        txn(3'd0, 8'h60, 32'h0000_0010, 128'd0, 1'b0, 0);
        txn(3'd0, 8'h61, 32'h0000_0030, 128'd0, 1'b1, 0);
        chk("final_viol", viol_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
